// File: rtl/montgomery_mult_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier: FSM states,
// default operand width and the {ai,q} operand-select codes.
package mont_pkg;

   localparam int DEFAULT_N = 512;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      SEL  = 3'd2,
      ADD  = 3'd3,
      NXT  = 3'd4,
      SUB  = 3'd5,
      DONE = 3'd6
   } state_t;

   // Operand-select code is {ai, q}.
   localparam logic [1:0] SEL_ZERO = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b10;
   localparam logic [1:0] SEL_M    = 2'b01;
   localparam logic [1:0] SEL_BM   = 2'b11;

   function automatic logic [1:0] sel_code(input logic ai, input logic c0, input logic b0);
      return {ai, c0 ^ (ai & b0)};
   endfunction

endpackage

// File: rtl/montgomery_mult_if.sv
// Request/response bundle between the RSA sequencer (master) and montgomery_mult (slave).
// Handshake: start is a one-cycle request honoured only while idle; done pulses once when result is valid.
interface montgomery_mult_if #(
   parameter int N = 512
);
   logic         start;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic [N-1:0] in_m;
   logic [N-1:0] result;
   logic         done;
   logic         busy;

   modport master (
      output start, in_a, in_b, in_m,
      input  result, done, busy
   );

   modport slave (
      input  start, in_a, in_b, in_m,
      output result, done, busy
   );
endinterface

// File: rtl/montgomery_mult_adder.sv
// Multi-cycle chunked adder/subtractor: processes ADDER_SIZE bits per cycle, pulses done
// once the full W-bit result is registered. Operands must stay stable from start to done.
module montgomery_mult_adder #(
   parameter int W          = 514,
   parameter int ADDER_SIZE = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         subtract,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic [W-1:0] result,
   output logic         done
);
   localparam int NCH = (W + ADDER_SIZE - 1) / ADDER_SIZE;
   localparam int PW  = NCH * ADDER_SIZE;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [KW-1:0] LAST_K = KW'(NCH - 1);

   logic [PW-1:0]         a_pad;
   logic [PW-1:0]         b_pad;
   logic [PW-1:0]         res_pad;
   logic [KW-1:0]         k;
   logic [31:0]           base;
   logic                  run;
   logic                  sub_q;
   logic                  carry;
   logic [ADDER_SIZE-1:0] a_chunk;
   logic [ADDER_SIZE-1:0] b_chunk;
   logic [ADDER_SIZE:0]   chunk_sum;
   logic                  unused_pad;

   always_comb begin
      a_pad = '0;
      b_pad = '0;
      a_pad[W-1:0] = in_a;
      b_pad[W-1:0] = in_b;
   end

   assign base    = 32'(k) * 32'(ADDER_SIZE);
   assign a_chunk = a_pad[base +: ADDER_SIZE];
   // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   assign b_chunk = b_pad[base +: ADDER_SIZE] ^ {ADDER_SIZE{sub_q}};
   assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (ADDER_SIZE + 1)'(carry);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run     <= 1'b0;
         sub_q   <= 1'b0;
         carry   <= 1'b0;
         k       <= '0;
         res_pad <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            run   <= 1'b1;
            sub_q <= subtract;
            carry <= subtract;
            k     <= '0;
         end else if (run) begin
            res_pad[base +: ADDER_SIZE] <= chunk_sum[ADDER_SIZE-1:0];
            carry <= chunk_sum[ADDER_SIZE];
            if (k == LAST_K) begin
               run  <= 1'b0;
               done <= 1'b1;
            end else begin
               k <= k + 1'b1;
            end
         end
      end
   end

   assign result = res_pad[W-1:0];
   // Bits above W only exist to round the width up to whole chunks.
   assign unused_pad = &{1'b0, res_pad};

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial Montgomery multiplier, result = A*B*2^-N mod M, driving one chunked adder.
// Define MONT_SKIP_ZERO_EN to bypass the adder on {ai,q}=00 iterations (not constant-time).
module montgomery_mult
   import mont_pkg::*;
#(
   parameter int N          = DEFAULT_N,
   parameter int ADDER_SIZE = 4
) (
   input  logic             clk,
   input  logic             reset,
   montgomery_mult_if.slave bus,
   output state_t           dbg_state
);
   localparam int W  = N + 2;
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_I = IW'(N - 1);

   state_t        state;
   state_t        state_next;
   logic          entered;
   logic [N-1:0]  a_r;
   logic [N-1:0]  b_r;
   logic [N-1:0]  m_r;
   logic [N:0]    bm_r;
   logic [N:0]    c_r;
   logic [IW-1:0] i_r;
   logic [1:0]    sel_r;
   logic [1:0]    sel_now;
   logic [N-1:0]  result_r;
   logic [N:0]    x_op;
   logic          done_now;
   logic          busy_now;

   logic          adder_start;
   logic          adder_sub;
   logic [W-1:0]  adder_a;
   logic [W-1:0]  adder_b;
   logic [W-1:0]  adder_res;
   logic          adder_done;

   assign sel_now = sel_code(a_r[i_r], c_r[0], b_r[0]);

   // entered is high in the first cycle of any state, so adder start fires once per wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         entered <= 1'b0;
      end else begin
         state   <= state_next;
         entered <= (state_next != state);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.start) state_next = PRE;
         PRE:  if (adder_done) state_next = SEL;
         SEL: begin
`ifdef MONT_SKIP_ZERO_EN
            state_next = (sel_now == SEL_ZERO) ? NXT : ADD;
`else
            state_next = ADD;
`endif
         end
         ADD:  if (adder_done) state_next = NXT;
         NXT:  state_next = (i_r == LAST_I) ? SUB : SEL;
         SUB:  if (adder_done) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      adder_start = 1'b0;
      adder_sub   = 1'b0;
      adder_a     = '0;
      adder_b     = '0;
      done_now    = 1'b0;
      busy_now    = (state != IDLE);
      x_op        = '0;
      case (sel_r)
         SEL_B:   x_op = {1'b0, b_r};
         SEL_M:   x_op = {1'b0, m_r};
         SEL_BM:  x_op = bm_r;
         default: x_op = '0;
      endcase
      case (state)
         PRE: begin
            adder_start = entered;
            adder_a     = {2'b00, b_r};
            adder_b     = {2'b00, m_r};
         end
         ADD: begin
            adder_start = entered;
            adder_a     = {1'b0, c_r};
            adder_b     = {1'b0, x_op};
         end
         SUB: begin
            adder_start = entered;
            adder_sub   = 1'b1;
            adder_a     = {1'b0, c_r};
            adder_b     = {2'b00, m_r};
         end
         DONE: done_now = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r      <= '0;
         b_r      <= '0;
         m_r      <= '0;
         bm_r     <= '0;
         c_r      <= '0;
         i_r      <= '0;
         sel_r    <= '0;
         result_r <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               a_r <= bus.in_a;
               b_r <= bus.in_b;
               m_r <= bus.in_m;
               c_r <= '0;
               i_r <= '0;
            end
            PRE: if (adder_done) bm_r <= adder_res[N:0];
            SEL: begin
               sel_r <= sel_now;
`ifdef MONT_SKIP_ZERO_EN
               if (sel_now == SEL_ZERO) c_r <= c_r >> 1;
`endif
            end
            // C + X is always even, so the halving drops a zero bit.
            ADD: if (adder_done) c_r <= adder_res[N+1:1];
            NXT: if (i_r != LAST_I) i_r <= i_r + 1'b1;
            // Sign bit N+1 set means C < M, so C is already reduced.
            SUB: if (adder_done) result_r <= adder_res[N+1] ? c_r[N-1:0] : adder_res[N-1:0];
            default: ;
         endcase
      end
   end

   montgomery_mult_adder #(
      .W          (W),
      .ADDER_SIZE (ADDER_SIZE)
   ) u_adder (
      .clk      (clk),
      .rst_n    (~reset),
      .start    (adder_start),
      .subtract (adder_sub),
      .in_a     (adder_a),
      .in_b     (adder_b),
      .result   (adder_res),
      .done     (adder_done)
   );

   assign bus.result = result_r;
   assign bus.done   = done_now;
   assign bus.busy   = busy_now;
   assign dbg_state  = state;

endmodule

// File: doc/montgomery_mult.md
Name: montgomery_mult

Overview:
- Bit-serial Montgomery modular multiplier for the RSA datapath: result = A·B·2^-N mod M.
- Sits directly upstream of the multi-cycle chunked adder/subtractor and is its only client.
- Issues one adder operation per bit of A, then one final conditional subtraction.
- Drives the adder's start/subtract/in_a/in_b and consumes its result/done.

Parameters:
N, 512, operand width in bits (adder datapath is fixed at 512; other values unsupported).
ADDER_SIZE, 4, chunk width forwarded to the adder instance.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request; sampled only in IDLE.
in_a  input  N  multiplier A; requires A < M.
in_b  input  N  multiplicand B; requires B < M.
in_m  input  N  modulus M; must be odd.
result  output  N  A·B·2^-N mod M; valid from the done cycle until the next accepted start.
done  output  1  one-cycle pulse when result is valid.
busy  output  1  high from the cycle after start is accepted until the done cycle inclusive.

Behaviour:
- Reset: async, active-high.
  - State=IDLE; result=0, done=0, busy=0; C, A, B, M, BM registers and the bit counter cleared.
  - Adder instance reset is driven by ~reset.
  - Reset mid-operation aborts immediately; no done is produced.
- Accumulator C is N+1 bits. Invariant: C < 2M at every iteration boundary.
- States:
  - IDLE: on start, latch in_a, in_b, in_m; clear C and counter i; go to PRE.
  - PRE: pulse adder start with in_a={0,B}, in_b={0,M}, subtract=0. Wait for adder done. Store BM = result[N:0] (B+M < 2M, fits N+1 bits). Go to SEL.
  - SEL: ai = A[i]; q = C[0] XOR (ai AND B[0]). Operand X = 0, B, M or BM for {ai,q} = 00, 10, 01, 11 respectively. Go to ADD.
  - ADD: one-cycle adder start with in_a=C, in_b=X. Wait for done. The 514-bit sum is always even; C <= sum[N+1:1]. Go to NXT.
  - NXT: if i == N-1, go to SUB; else i <= i+1 and go to SEL.
  - SUB: adder start with in_a=C, in_b={0,M}, subtract=1. Wait for done. If result[N+1]=0 (no borrow, C ≥ M), result <= diff[N-1:0]; else result <= C[N-1:0]. Go to DONE.
  - DONE: done=1 for one cycle; return to IDLE.
- Adder handshake:
  - Adder start is a single-cycle pulse issued on entry to the waiting state.
  - Operands are held stable until adder done.
  - Adder done is the only completion event; no timeout.
- start while busy is ignored. start in the DONE cycle is ignored; it is accepted one cycle later in IDLE.
- Counter i: log2(N) bits. Wrap from N-1 is never taken; exit occurs first.
- Latency: 1 + (N+2)·(adder latency + ~2) cycles, dominated by the adder. Exact count is not part of the contract; the bench checks done and result only.
- Inputs that violate A<M, B<M or odd M give an undefined result but the FSM still terminates.

Optional Feature:
- Macro MONT_SKIP_ZERO_EN.
- Defined: when {ai,q}=00, ADD is bypassed and C <= C>>1 in one cycle with no adder start. This saves power and time for sparse A.
- Undefined: every iteration issues an adder operation (with X=0), so the adder activity count is data-independent (constant-time, side-channel safe).
- Results are identical with and without the macro.

Decomposition:
- Package mont_pkg holds: the state enumeration (IDLE, PRE, SEL, ADD, NXT, SUB, DONE), default N, and the operand-select encoding constants.
- One sub-module instance, the existing chunked adder, named u_adder. The FSM and registers live in montgomery_mult.

Test Plan:
- M=2^512-1, A=3, B=5 -> result=15, exactly one done pulse, busy falls after done.
- M=2^512-1, A=M-1, B=M-1 -> result=1; exercises the final subtraction (no-borrow branch).
- A=0, B=arbitrary < M -> result=0; with MONT_SKIP_ZERO_EN, adder start count = 2 (PRE + SUB); without it, N+2.
- Random odd 512-bit M with random A, B < M (100 vectors) -> matches golden model A·B·2^-512 mod M.
- Assert reset midway through iteration ~200 -> done never pulses, busy=0, result=0; a new start then completes correctly.
- start re-pulsed while busy and in the DONE cycle -> ignored; a start in the cycle after DONE is accepted and produces a correct second result.
